dot_vec_loader: RTL
===================

Name: dot_vec_loader

Overview:
- Writer/sequencer for the 16-element dot-product MAC.
- Accepts a byte stream over a valid/ready handshake and fills two 16x8 operand banks: bank A first, then bank B.
- Once both banks are full, it drives the MAC's 5-bit count index and supplies the operand pair for each index.
- When the sweep completes, it captures the MAC's 20-bit sum into a result register and pulses done.

Parameters:
- DW, 8, operand width in bits.
- DEPTH, 16, elements per bank; must be a power of 2.
- AW, 4, bank address width; equals log2(DEPTH).
- CW, 5, count output width; equals AW+1.
- ACCW, 20, accumulator and result width; equals 2*DW + AW.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a byte to load.
- in_data  input  DW  operand byte.
- in_ready  output  1  block accepts a byte this cycle.
- abort  input  1  synchronous return to LOAD_A; loaded data is discarded.
- cnt  output  CW  count index driven to the MAC.
- a_data  output  DW  bank A operand at index cnt.
- b_data  output  DW  bank B operand at index cnt.
- acc_in  input  ACCW  running sum returned from the MAC.
- busy  output  1  high in RUN and CAPTURE.
- done  output  1  one-cycle pulse when result is updated.
- result  output  ACCW  last captured dot product.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state=LOAD_A, wr_ptr=0, cnt=0, result=0.
  - done=0, busy=0, in_ready=1.
  - Bank contents are not reset; they are fully rewritten before any use.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready=1 only in LOAD_A and LOAD_B; it is combinational from state.
  - Bytes offered in any other state are ignored (not accepted, not buffered).
- LOAD_A:
  - Each accepted byte is written to bankA[wr_ptr]; wr_ptr increments.
  - On acceptance with wr_ptr==DEPTH-1: wr_ptr wraps to 0 and state moves to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, but writes bankB.
  - On the 16th byte: state=RUN, cnt=0.
- RUN:
  - cnt increments by 1 every cycle: 0,1,...,DEPTH+1 (0..17), i.e. 18 cycles in RUN.
  - After the cycle with cnt==DEPTH+1: state=CAPTURE; cnt holds at 17.
- CAPTURE (1 cycle):
  - result<=acc_in; done=1 for exactly this cycle; state moves to LOAD_A.
  - cnt returns to 0 on the same edge.
- Operand read (combinational):
  - a_data=bankA[cnt[AW-1:0]] and b_data=bankB[cnt[AW-1:0]] when cnt<=DEPTH-1; otherwise both are 0.
  - The MAC therefore adds 0 for cnt 16 and 17.
- Latency:
  - From the 32nd accepted byte to the done pulse: 19 cycles (18 RUN + 1 CAPTURE).
  - New data may be accepted on the cycle immediately after done.
- result behaviour:
  - Holds its value until the next CAPTURE.
  - abort and a fresh load do not clear it; only rst does.
- abort:
  - Sampled only on rising edges; it takes priority over all transitions.
  - Effect: state=LOAD_A, wr_ptr=0, cnt=0, done=0.
  - If in_valid && in_ready in the same cycle, the byte is dropped.
- Arithmetic: the block performs no arithmetic on the data path. The maximum legal sum, 16*255*255=1040400 (0xFE010), fits in ACCW=20 bits with no overflow.
- Reset mid-RUN: all outputs return to their reset values immediately (not at the next clock edge). Partial bank data is ignored and the next load overwrites it.
- Illegal/unused state encodings recover to LOAD_A.

Test Plan:
- Reset, then stream A=all 1, B=all 1 with in_valid held high. Required response:
  - in_ready falls after the 32nd byte.
  - cnt sweeps 0..17.
  - done pulses 19 cycles after the last byte, with result=16 (0x00010).
- A[i]=i, B[i]=1 (i=0..15), with in_valid toggled 1/0 every other cycle. Required response:
  - Exactly 32 accepted bytes.
  - result=120 (0x00078); done is a single cycle.
- A=all 255, B=all 255. Required response:
  - result=1040400 (0xFE010).
  - a_data/b_data=0 while cnt=16 and cnt=17.
- In RUN at cnt=7, assert in_valid with data 0xAA. Required response:
  - in_ready=0; the byte is not accepted.
  - The bank contents and the final result are unchanged versus a run without the intrusion.
- abort after 20 bytes, then reload A=2s, B=3s. Required response:
  - wr_ptr restarts at bankA[0].
  - result=96 (0x00060).
  - The prior result is held until this capture.
- rst asserted asynchronously mid-RUN (between clock edges). Required response:
  - cnt=0, busy=0, in_ready=1 and result=0 without waiting for a clk edge.
  - A subsequent full load gives the correct sum.

Source files
------------

// File: rtl/dot_vec_loader.sv
// rtl/dot_vec_loader.sv - operand bank loader and count sequencer for the 16-element dot-product MAC
// Loads bank A then bank B from a byte stream, sweeps cnt for the MAC, captures the sum.
module dot_vec_loader #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 5,
  parameter int ACCW  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  input  logic            abort,
  output logic [CW-1:0]   cnt,
  output logic [DW-1:0]   a_data,
  output logic [DW-1:0]   b_data,
  input  logic [ACCW-1:0] acc_in,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] result
);

  localparam logic [2:0] S_LOAD_A  = 3'd0;
  localparam logic [2:0] S_LOAD_B  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;

  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] bank_a [DEPTH];
  logic [DW-1:0] bank_b [DEPTH];
  logic          accept;
  logic          last_byte;

  assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign busy      = (state == S_RUN) || (state == S_CAPTURE);
  assign accept    = in_valid && in_ready && !abort;
  assign last_byte = (wr_ptr == AW'(DEPTH - 1));

  // Banks carry no reset: every entry is rewritten before a sweep reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == S_LOAD_A) begin
        bank_a[wr_ptr] <= in_data;
      end else begin
        bank_b[wr_ptr] <= in_data;
      end
    end
  end

  // Indices DEPTH and DEPTH+1 feed zeros so the MAC pipeline drains without adding.
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (cnt < CW'(DEPTH)) begin
      a_data = bank_a[cnt[AW-1:0]];
      b_data = bank_b[cnt[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LOAD_A;
      wr_ptr <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= S_LOAD_A;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          S_LOAD_A: begin
            if (accept) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (last_byte) begin
                state <= S_LOAD_B;
              end
            end
          end
          S_LOAD_B: begin
            if (accept) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (last_byte) begin
                state <= S_RUN;
                cnt   <= '0;
              end
            end
          end
          S_RUN: begin
            if (cnt == CW'(DEPTH + 1)) begin
              state <= S_CAPTURE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CAPTURE: begin
            result <= acc_in;
            done   <= 1'b1;
            state  <= S_LOAD_A;
            cnt    <= '0;
          end
          default: begin
            state  <= S_LOAD_A;
            wr_ptr <= '0;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule
